// File: rtl/lut_arbiter.sv
// Arbiter that shares one combinational 4-bit lookup among N requesters.
// Define LUT_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest index wins.
module lut_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [4*N-1:0]   din,
    output logic [3:0]       lut_in,
    input  logic [3:0]       lut_out,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     ack,
    output logic [3:0]       dout,
    output logic [IDW-1:0]   dout_id,
    output logic             dout_valid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    logic [3:0]     op_reg;
    logic [IDW-1:0] id_reg;
    logic [IDW-1:0] win;

`ifdef LUT_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr;

    // Scan downward so the requester nearest after the pointer overwrites the others.
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        int idx;
        w = p;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(p) + k) % N;
            if (r[idx]) w = IDW'(idx);
        end
        return w;
    endfunction

    always_comb win = pick(req, ptr);
`else
    function automatic logic [IDW-1:0] pick(input logic [N-1:0] r);
        logic [IDW-1:0] w;
        w = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (r[k]) w = IDW'(k);
        end
        return w;
    endfunction

    always_comb win = pick(req);
`endif

    assign lut_in = op_reg;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_reg     <= '0;
            id_reg     <= '0;
            gnt        <= '0;
            ack        <= '0;
            dout       <= '0;
            dout_id    <= '0;
            dout_valid <= 1'b0;
`ifdef LUT_ARB_ROUND_ROBIN_EN
            ptr        <= IDW'(N - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        id_reg <= win;
                        op_reg <= din[{win, 2'b00} +: 4];
                        gnt    <= ONE << win;
                        state  <= ISSUE;
                    end
                end
                // op_reg drives the lookup for the whole cycle; capture its result here
                ISSUE: begin
                    dout       <= lut_out;
                    dout_id    <= id_reg;
                    dout_valid <= 1'b1;
                    ack        <= ONE << id_reg;
                    state      <= RESP;
                end
                RESP: begin
                    dout_valid <= 1'b0;
                    ack        <= '0;
                    gnt        <= '0;
`ifdef LUT_ARB_ROUND_ROBIN_EN
                    ptr        <= id_reg;
`endif
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_arbiter.sv
// Self-checking bench for lut_arbiter: vector table, directed corner sequences and a random run.
module tb_lut_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req = '0;
    logic [4*N-1:0]   din = '0;
    logic [3:0]       lut_in;
    logic [3:0]       lut_out;
    logic [N-1:0]     gnt;
    logic [N-1:0]     ack;
    logic [3:0]       dout;
    logic [IDW-1:0]   dout_id;
    logic             dout_valid;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    // Stand-in for the shared outFunc instance.
    function automatic logic [3:0] outfunc(input logic [3:0] x);
        case (x)
            4'h0: return 4'hc;  4'h1: return 4'h7;  4'h2: return 4'h9;  4'h3: return 4'h5;
            4'h4: return 4'h1;  4'h5: return 4'he;  4'h6: return 4'hd;  4'h7: return 4'h2;
            4'h8: return 4'hb;  4'h9: return 4'h4;  4'ha: return 4'h0;  4'hb: return 4'h8;
            4'hc: return 4'h6;  4'hd: return 4'h3;  4'he: return 4'ha;  default: return 4'h0;
        endcase
    endfunction

    assign lut_out = outfunc(lut_in);

    lut_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .lut_in(lut_in), .lut_out(lut_out),
        .gnt(gnt), .ack(ack), .dout(dout), .dout_id(dout_id), .dout_valid(dout_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic wait_ack(input string name, output int who, output int cyc);
        who = -1;
        cyc = 0;
        for (int c = 1; c <= 12 && who < 0; c++) begin
            tick;
            if (ack != '0) begin
                cyc = c;
                for (int j = 0; j < N; j++) if (ack[j]) who = j;
            end
        end
        if (who < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no ack within 12 cycles", name);
        end
    endtask

    typedef struct {
        logic [3:0]  rq;
        logic [15:0] d;
        logic [1:0]  id;
        logic [3:0]  res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int who, cyc, busy_cnt;
        logic [3:0] sexp[4];
        logic [3:0] cap_dout;
        logic [1:0] cap_id;
        logic [3:0] eg, ea;
        int phase, mid, mptr;
        logic [3:0] mval, ldout;
        logic [1:0] lid;
        bit found;

        // After reset the pointer sits at N-1, so both selection modes pick the lowest set bit.
        vecs[0] = '{4'b0010, 16'h0030, 2'd1, 4'h5};
        vecs[1] = '{4'b0001, 16'h0009, 2'd0, 4'h4};
        vecs[2] = '{4'b1000, 16'h6000, 2'd3, 4'hd};
        vecs[3] = '{4'b0100, 16'h0b00, 2'd2, 4'h8};
        vecs[4] = '{4'b1100, 16'h5e00, 2'd2, 4'ha};
        vecs[5] = '{4'b1010, 16'h8070, 2'd1, 4'h2};
        vecs[6] = '{4'b1111, 16'hfa60, 2'd0, 4'hc};
        vecs[7] = '{4'b0110, 16'h0c40, 2'd1, 4'h1};

        tick;
        tick;
        check("reset_outputs", {gnt, ack, dout, dout_id, dout_valid, busy, lut_in}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_reset;
            req = vecs[i].rq;
            din = vecs[i].d;
            tick;
            check("vec_grant", {busy, gnt, ack, dout_valid}, {1'b1, 4'b0001 << vecs[i].id, 4'b0, 1'b0});
            tick;
            check("vec_ack", {ack, dout_valid, dout, dout_id},
                  {4'b0001 << vecs[i].id, 1'b1, vecs[i].res, vecs[i].id});
            req = '0;
            tick;
            check("vec_end", {busy, gnt, ack, dout_valid, dout, dout_id},
                  {1'b0, 4'b0, 4'b0, 1'b0, vecs[i].res, vecs[i].id});
        end

        // All four request at once and each drops after its own ack.
        sexp = '{4'hc, 4'hd, 4'h0, 4'h0};
        do_reset;
        req = 4'b1111;
        din = 16'hfa60;
        for (int k = 0; k < 4; k++) begin
            wait_ack("simul_wait", who, cyc);
            check("simul_id", who, k);
            check("simul_dout", dout, sexp[k]);
            check("simul_spacing", cyc, (k == 0) ? 2 : 3);
            if (who >= 0) req[who] = 1'b0;
        end
        tick;
        tick;

        // Requesters 0 and 2 keep requesting continuously.
        do_reset;
        req = 4'b0101;
        din = 16'h0304;
        for (int k = 0; k < 4; k++) begin
            wait_ack("fair_wait", who, cyc);
`ifdef LUT_ARB_ROUND_ROBIN_EN
            check("fair_id", who, (k % 2 == 0) ? 0 : 2);
`else
            check("fair_id", who, 0);
`endif
        end
        req = '0;
        tick;
        tick;
        tick;

        // Reset lands on the ISSUE cycle after the pointer has moved off N-1.
        do_reset;
        req = 4'b0001;
        din = 16'h0504;
        wait_ack("rst_pre", who, cyc);
        req = '0;
        tick;
        req = 4'b0101;
        tick;
        check("rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick;
        check("rst_outputs", {gnt, ack, dout, dout_id, dout_valid, busy, lut_in}, 32'h0);
        rst = 1'b0;
        tick;
        check("rst_regrant", gnt, 4'b0001);
        tick;
        req = '0;
        tick;
        tick;

        // One-cycle request; operand changes right after the grant.
        do_reset;
        din = 16'h6000;
        req = 4'b1000;
        tick;
        req = '0;
        din = 16'h0000;
        busy_cnt = busy;
        cap_dout = '0;
        cap_id   = '0;
        for (int c = 0; c < 6; c++) begin
            tick;
            busy_cnt += busy;
            if (dout_valid) begin
                cap_dout = dout;
                cap_id   = dout_id;
            end
        end
        check("pulse_result", {cap_dout, cap_id}, {4'hd, 2'd3});
        check("pulse_busy_cycles", busy_cnt, 2);

        // Random run against a transaction-timeline model.
        do_reset;
        phase = 0;
        mid   = 0;
        mptr  = N - 1;
        mval  = '0;
        ldout = '0;
        lid   = '0;
        for (int cy = 0; cy < 600; cy++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    din[4*i +: 4] = 4'($urandom);
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end
            end
            if (phase != 0) din[4*mid +: 4] = 4'($urandom);
            tick;
            case (phase)
                0: begin
                    if (req != '0) begin
                        found = 1'b0;
`ifdef LUT_ARB_ROUND_ROBIN_EN
                        for (int k = 1; k <= N; k++) begin
                            if (!found && req[(mptr + k) % N]) begin
                                mid = (mptr + k) % N;
                                found = 1'b1;
                            end
                        end
`else
                        for (int k = 0; k < N; k++) begin
                            if (!found && req[k]) begin
                                mid = k;
                                found = 1'b1;
                            end
                        end
`endif
                        mval  = outfunc(din[4*mid +: 4]);
                        phase = 1;
                    end
                end
                1: phase = 2;
                default: begin
                    phase = 0;
                    mptr  = mid;
                end
            endcase
            eg = (phase != 0) ? (4'b0001 << mid) : 4'b0000;
            ea = (phase == 2) ? (4'b0001 << mid) : 4'b0000;
            if (phase == 2) begin
                ldout = mval;
                lid   = IDW'(mid);
            end
            check("rand_ctl", {busy, gnt, ack, dout_valid}, {phase != 0, eg, ea, phase == 2});
            check("rand_data", {dout, dout_id}, {ldout, lid});
            if (phase == 2) req[mid] = 1'b0;
        end
        req = '0;
        tick;
        tick;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
